// File: rtl/enigma_block_serializer_if.sv
// Byte-stream interface carrying serialized cipher blocks downstream.
// The serializer drives data/valid/first/last; the consumer drives ready.
interface enigma_block_serializer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_first;
    logic       out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_first,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_first,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/enigma_block_serializer.sv
// Output-side serializer for the 16-byte cipher datapath. Captures a 4x4
// result block plus its mode tag and streams it as an optional header byte
// followed by 16 data bytes (w0..w3, x0..x3, y0..y3, z0..z3). An active and
// a pending slot let the next block be handed over while the current drains.
module enigma_block_serializer #(
    parameter bit         HEADER_EN = 1'b1,
    parameter logic [7:0] HDR_BASE  = 8'hA0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       mode_in,
    input  logic [7:0] w0, w1, w2, w3,
    input  logic [7:0] x0, x1, x2, x3,
    input  logic [7:0] y0, y1, y2, y3,
    input  logic [7:0] z0, z1, z2, z3,
    output logic       load_rdy,
    output logic       busy,
    output logic       overflow,
    input  logic       clr_ovf,
    enigma_block_serializer_if.master strm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    // A freshly activated block starts at its header, or straight at w0.
    localparam state_t START_ST = HEADER_EN ? HDR : DATA;

    // Byte index 0 is w0, index 15 is z3.
    logic [15:0][7:0] in_blk;
    assign in_blk = {z3, z2, z1, z0, y3, y2, y1, y0,
                     x3, x2, x1, x0, w3, w2, w1, w0};

    // Registered state
    state_t           state;
    logic [3:0]       cnt;
    logic [15:0][7:0] act_blk;
    logic             act_mode;
    logic [15:0][7:0] pend_blk;
    logic             pend_mode;
    logic             pend_full;

    // Next-state values
    state_t           nxt_state;
    logic [3:0]       nxt_cnt;
    logic [15:0][7:0] nxt_act_blk;
    logic             nxt_act_mode;
    logic [15:0][7:0] nxt_pend_blk;
    logic             nxt_pend_mode;
    logic             nxt_pend_full;
    logic [7:0]       nxt_data;
    logic             nxt_first;
    logic             nxt_last;
    logic             nxt_ovf;

    logic xfer;
    logic wrap;
    logic load_acc;
    logic load_drop;
    logic act_free;

    // Handshake events, slot bookkeeping and next output values.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path leaves it unassigned, which would infer a latch.
        xfer          = strm.out_valid && strm.out_ready;
        wrap          = xfer && (state == DATA) && (cnt == 4'd15);
        load_acc      = load && load_rdy;
        load_drop     = load && !load_rdy;
        // Active slot is empty now, or empties on this edge with nothing
        // pending to take its place.
        act_free      = (state == IDLE) || (wrap && !pend_full);

        nxt_state     = state;
        nxt_cnt       = cnt;
        nxt_act_blk   = act_blk;
        nxt_act_mode  = act_mode;
        nxt_pend_blk  = pend_blk;
        nxt_pend_mode = pend_mode;
        nxt_pend_full = pend_full;

        case (state)
            IDLE: begin
                if (load_acc) begin
                    nxt_act_blk  = in_blk;
                    nxt_act_mode = mode_in;
                    nxt_state    = START_ST;
                    nxt_cnt      = 4'd0;
                end
            end
            HDR: begin
                if (xfer) begin
                    nxt_state = DATA;
                    nxt_cnt   = 4'd0;
                end
            end
            DATA: begin
                if (xfer) begin
                    if (cnt == 4'd15) begin
                        nxt_cnt = 4'd0;
                        if (pend_full) begin
                            // Promote pending without a bubble.
                            nxt_act_blk   = pend_blk;
                            nxt_act_mode  = pend_mode;
                            nxt_pend_full = 1'b0;
                            nxt_state     = START_ST;
                        end else if (load_acc) begin
                            // A load landing on the final byte goes straight
                            // to active so it is not stranded in pending.
                            nxt_act_blk  = in_blk;
                            nxt_act_mode = mode_in;
                            nxt_state    = START_ST;
                        end else begin
                            nxt_state = IDLE;
                        end
                    end else begin
                        nxt_cnt = cnt + 4'd1;
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = 4'd0;
            end
        endcase

        if (load_acc && !act_free) begin
            nxt_pend_blk  = in_blk;
            nxt_pend_mode = mode_in;
            nxt_pend_full = 1'b1;
        end

        case (nxt_state)
            HDR:     nxt_data = HDR_BASE | {7'b0, nxt_act_mode};
            DATA:    nxt_data = nxt_act_blk[nxt_cnt];
            default: nxt_data = 8'h00;
        endcase
        nxt_first = (nxt_state == HDR) ||
                    ((nxt_state == DATA) && (nxt_cnt == 4'd0) && !HEADER_EN);
        nxt_last  = (nxt_state == DATA) && (nxt_cnt == 4'd15);

        // A new drop wins over a simultaneous clear.
        if (load_drop)
            nxt_ovf = 1'b1;
        else if (clr_ovf)
            nxt_ovf = 1'b0;
        else
            nxt_ovf = overflow;
    end

    // FSM, slot flags and registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values and all of them update together.
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            pend_full      <= 1'b0;
            load_rdy       <= 1'b1;
            busy           <= 1'b0;
            overflow       <= 1'b0;
            strm.out_valid <= 1'b0;
            strm.out_data  <= 8'h00;
            strm.out_first <= 1'b0;
            strm.out_last  <= 1'b0;
        end else begin
            state          <= nxt_state;
            cnt            <= nxt_cnt;
            pend_full      <= nxt_pend_full;
            load_rdy       <= !nxt_pend_full;
            busy           <= (nxt_state != IDLE);
            overflow       <= nxt_ovf;
            strm.out_valid <= (nxt_state != IDLE);
            strm.out_data  <= nxt_data;
            strm.out_first <= nxt_first;
            strm.out_last  <= nxt_last;
        end
    end

    // Block payload storage for both slots.
    always_ff @(posedge clk) begin
        // NOTE: payload storage is deliberately not reset; it is only ever
        // read while the FSM or the pending flag marks the slot occupied.
        act_blk   <= nxt_act_blk;
        act_mode  <= nxt_act_mode;
        pend_blk  <= nxt_pend_blk;
        pend_mode <= nxt_pend_mode;
    end

endmodule

// File: tb/tb_enigma_block_serializer.sv
// Directed bench for enigma_block_serializer: one instance with the header
// enabled, one without, sharing the load side and clear/reset inputs.
module tb_enigma_block_serializer;

    logic       clk;
    logic       rst;
    logic       load;
    logic       mode_in;
    logic       clr_ovf;
    logic [7:0] w0, w1, w2, w3, x0, x1, x2, x3;
    logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
    logic       load_rdy_h, busy_h, ovf_h;
    logic       load_rdy_n, busy_n, ovf_n;

    int vectors;
    int miscompares;

    enigma_block_serializer_if sh ();
    enigma_block_serializer_if sn ();

    enigma_block_serializer #(.HEADER_EN(1'b1), .HDR_BASE(8'hA0)) dut_h (
        .clk(clk), .rst(rst), .load(load), .mode_in(mode_in),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .z0(z0), .z1(z1), .z2(z2), .z3(z3),
        .load_rdy(load_rdy_h), .busy(busy_h), .overflow(ovf_h),
        .clr_ovf(clr_ovf), .strm(sh.master)
    );

    enigma_block_serializer #(.HEADER_EN(1'b0), .HDR_BASE(8'hA0)) dut_n (
        .clk(clk), .rst(rst), .load(load), .mode_in(mode_in),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .z0(z0), .z1(z1), .z2(z2), .z3(z3),
        .load_rdy(load_rdy_n), .busy(busy_n), .overflow(ovf_n),
        .clr_ovf(clr_ovf), .strm(sn.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_block(input logic [7:0] base);
        w0 = base;          w1 = base + 8'd1;  w2 = base + 8'd2;  w3 = base + 8'd3;
        x0 = base + 8'd4;   x1 = base + 8'd5;  x2 = base + 8'd6;  x3 = base + 8'd7;
        y0 = base + 8'd8;   y1 = base + 8'd9;  y2 = base + 8'd10; y3 = base + 8'd11;
        z0 = base + 8'd12;  z1 = base + 8'd13; z2 = base + 8'd14; z3 = base + 8'd15;
    endtask

    task automatic load_block(input logic m, input logic [7:0] base);
        set_block(base);
        mode_in = m;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
    endtask

    // Expected byte i of a headered block: header, then base+0..base+15.
    function automatic logic [7:0] hdr_byte(input logic m, input logic [7:0] base, input int i);
        if (i == 0)
            return 8'hA0 | {7'b0, m};
        return base + 8'(i - 1);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if ({sh.out_valid, sh.out_data, sh.out_first, sh.out_last, busy_h, ovf_h, load_rdy_h}
            !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_h: got v=%b d=%h f=%b l=%b busy=%b ovf=%b rdy=%b want 0 00 0 0 0 0 1",
                     sh.out_valid, sh.out_data, sh.out_first, sh.out_last, busy_h, ovf_h, load_rdy_h);
        end
        vectors++;
        if ({sn.out_valid, sn.out_data, sn.out_first, sn.out_last, busy_n, ovf_n, load_rdy_n}
            !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_n: got v=%b d=%h f=%b l=%b busy=%b ovf=%b rdy=%b want 0 00 0 0 0 0 1",
                     sn.out_valid, sn.out_data, sn.out_first, sn.out_last, busy_n, ovf_n, load_rdy_n);
        end
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_single_block();
        logic [7:0] exp;
        sh.out_ready = 1'b1;
        load_block(1'b1, 8'h00);
        for (int k = 0; k < 17; k++) begin
            exp = hdr_byte(1'b1, 8'h00, k);
            vectors++;
            if ({sh.out_valid, sh.out_first, sh.out_last, sh.out_data, load_rdy_h}
                !== {1'b1, k == 0, k == 16, exp, 1'b1}) begin
                miscompares++;
                $display("FAIL single[%0d]: got v=%b f=%b l=%b d=%h rdy=%b want v=1 f=%b l=%b d=%h rdy=1",
                         k, sh.out_valid, sh.out_first, sh.out_last, sh.out_data, load_rdy_h,
                         k == 0, k == 16, exp);
            end
            tick();
        end
        vectors++;
        if ({sh.out_valid, busy_h} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_done: got v=%b busy=%b want 0 0", sh.out_valid, busy_h);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp;
        int idx;
        idx = 0;
        sh.out_ready = 1'b0;
        load_block(1'b1, 8'h00);
        for (int c = 0; c < 80 && idx < 17; c++) begin
            sh.out_ready = (c % 2 == 0);
            exp = hdr_byte(1'b1, 8'h00, idx);
            vectors++;
            if ({sh.out_valid, sh.out_first, sh.out_last, sh.out_data}
                !== {1'b1, idx == 0, idx == 16, exp}) begin
                miscompares++;
                $display("FAIL bp[%0d] cyc %0d: got v=%b f=%b l=%b d=%h want v=1 f=%b l=%b d=%h",
                         idx, c, sh.out_valid, sh.out_first, sh.out_last, sh.out_data,
                         idx == 0, idx == 16, exp);
            end
            if (sh.out_ready) idx++;
            tick();
        end
        vectors++;
        if (idx != 17 || busy_h !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_done: got transfers=%0d busy=%b want 17 0", idx, busy_h);
        end
        sh.out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        sh.out_ready = 1'b1;
        load_block(1'b0, 8'h10);
        for (int c = 0; c < 34; c++) begin
            exp = (c < 17) ? hdr_byte(1'b0, 8'h10, c) : hdr_byte(1'b1, 8'h20, c - 17);
            vectors++;
            if ({sh.out_valid, sh.out_first, sh.out_last, sh.out_data}
                !== {1'b1, c == 0 || c == 17, c == 16 || c == 33, exp}) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got v=%b f=%b l=%b d=%h want v=1 f=%b l=%b d=%h",
                         c, sh.out_valid, sh.out_first, sh.out_last, sh.out_data,
                         c == 0 || c == 17, c == 16 || c == 33, exp);
            end
            if (c == 3) begin
                vectors++;
                if (load_rdy_h !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_pending_rdy: got %b want 0", load_rdy_h);
                end
            end
            if (c == 17) begin
                vectors++;
                if (load_rdy_h !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_promote_rdy: got %b want 1", load_rdy_h);
                end
            end
            if (c == 2) begin
                set_block(8'h20);
                mode_in = 1'b1;
                load    = 1'b1;
            end else if (c == 3) begin
                load    = 1'b0;
                mode_in = 1'b0;
                set_block(8'hEE);
            end
            tick();
        end
        vectors++;
        if (busy_h !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done: got busy=%b want 0", busy_h);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        sh.out_ready = 1'b0;
        load_block(1'b0, 8'h30);
        load_block(1'b1, 8'h40);
        vectors++;
        if ({load_rdy_h, ovf_h} !== 2'b00) begin
            miscompares++;
            $display("FAIL ovf_full: got rdy=%b ovf=%b want 0 0", load_rdy_h, ovf_h);
        end
        set_block(8'h50);
        load = 1'b1;
        tick();
        vectors++;
        if (ovf_h !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: got %b want 1", ovf_h);
        end
        clr_ovf = 1'b1;
        tick();
        vectors++;
        if (ovf_h !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set_wins: got %b want 1", ovf_h);
        end
        load = 1'b0;
        tick();
        vectors++;
        if (ovf_h !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: got %b want 0", ovf_h);
        end
        clr_ovf = 1'b0;
        vectors++;
        if ({sh.out_valid, sh.out_first, sh.out_data} !== {1'b1, 1'b1, 8'hA0}) begin
            miscompares++;
            $display("FAIL ovf_stall_hold: got v=%b f=%b d=%h want 1 1 a0",
                     sh.out_valid, sh.out_first, sh.out_data);
        end
        sh.out_ready = 1'b1;
        for (int c = 0; c < 34; c++) begin
            exp = (c < 17) ? hdr_byte(1'b0, 8'h30, c) : hdr_byte(1'b1, 8'h40, c - 17);
            vectors++;
            if ({sh.out_valid, sh.out_data} !== {1'b1, exp}) begin
                miscompares++;
                $display("FAIL ovf_stream[%0d]: got v=%b d=%h want v=1 d=%h",
                         c, sh.out_valid, sh.out_data, exp);
            end
            tick();
        end
        vectors++;
        if ({sh.out_valid, busy_h} !== 2'b00) begin
            miscompares++;
            $display("FAIL ovf_dropped_block: got v=%b busy=%b d=%h want 0 0",
                     sh.out_valid, busy_h, sh.out_data);
        end
    endtask

    task automatic test_no_header();
        logic [7:0] exp;
        do_reset();
        sn.out_ready = 1'b1;
        sh.out_ready = 1'b1;
        load_block(1'b1, 8'hF0);
        for (int k = 0; k < 16; k++) begin
            exp = 8'hF0 + 8'(k);
            vectors++;
            if ({sn.out_valid, sn.out_first, sn.out_last, sn.out_data}
                !== {1'b1, k == 0, k == 15, exp}) begin
                miscompares++;
                $display("FAIL nohdr[%0d]: got v=%b f=%b l=%b d=%h want v=1 f=%b l=%b d=%h",
                         k, sn.out_valid, sn.out_first, sn.out_last, sn.out_data,
                         k == 0, k == 15, exp);
            end
            tick();
        end
        vectors++;
        if ({sn.out_valid, busy_n} !== 2'b00) begin
            miscompares++;
            $display("FAIL nohdr_done: got v=%b busy=%b want 0 0", sn.out_valid, busy_n);
        end
        tick();
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        sh.out_ready = 1'b1;
        load_block(1'b1, 8'h60);
        for (int c = 0; c < 6; c++) tick();
        vectors++;
        if (sh.out_data !== 8'h65) begin
            miscompares++;
            $display("FAIL midrst_pre: got d=%h want 65", sh.out_data);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({sh.out_valid, sh.out_data, sh.out_first, sh.out_last, busy_h, ovf_h, load_rdy_h}
            !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL midrst_async: got v=%b d=%h f=%b l=%b busy=%b ovf=%b rdy=%b want 0 00 0 0 0 0 1",
                     sh.out_valid, sh.out_data, sh.out_first, sh.out_last, busy_h, ovf_h, load_rdy_h);
        end
        #2 rst = 1'b0;
        tick();
        load_block(1'b0, 8'h70);
        vectors++;
        if ({sh.out_valid, sh.out_first, sh.out_data} !== {1'b1, 1'b1, 8'hA0}) begin
            miscompares++;
            $display("FAIL midrst_hdr: got v=%b f=%b d=%h want 1 1 a0",
                     sh.out_valid, sh.out_first, sh.out_data);
        end
        tick();
        vectors++;
        if ({sh.out_valid, sh.out_first, sh.out_data} !== {1'b1, 1'b0, 8'h70}) begin
            miscompares++;
            $display("FAIL midrst_data0: got v=%b f=%b d=%h want 1 0 70",
                     sh.out_valid, sh.out_first, sh.out_data);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        load         = 1'b0;
        mode_in      = 1'b0;
        clr_ovf      = 1'b0;
        sh.out_ready = 1'b0;
        sn.out_ready = 1'b1;
        set_block(8'h00);

        test_reset();
        test_single_block();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_no_header();
        test_reset_mid_block();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/enigma_block_serializer.md
Name: enigma_block_serializer

Overview:
- Output-side companion to the 16-byte parallel cipher datapath.
- Captures a completed 4x4 result block (rows w, x, y, z) plus its mode tag on a load strobe.
- Transmits the block as an 8-bit valid/ready byte stream: an optional header byte, then 16 data bytes.
- Double-buffered (active + pending slot), so the cipher can hand over the next block while the current one drains.

Parameters:
- HEADER_EN, 1: 1 = send a header byte before each block; 0 = data bytes only.
- HDR_BASE, 8'hA0: header byte value = HDR_BASE | {7'b0, mode tag}.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  single-cycle strobe: capture the block inputs and mode_in.
- mode_in  input  1  0 = block is encryption output; 1 = block is decryption output.
- w0,w1,w2,w3  input  8 each  block row 0.
- x0,x1,x2,x3  input  8 each  block row 1.
- y0,y1,y2,y3  input  8 each  block row 2.
- z0,z1,z2,z3  input  8 each  block row 3.
- load_rdy  output  1  pending slot empty, so a load this cycle is accepted (registered).
- out_data  output  8  current stream byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the byte.
- out_first  output  1  current byte is the first byte of a block (header, or w0 when HEADER_EN=0).
- out_last  output  1  current byte is z3.
- busy  output  1  active slot occupied.
- overflow  output  1  sticky flag: a load was dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst=1): FSM IDLE; both slots empty; byte counter 0; out_valid=0, out_data=8'h00, out_first=0, out_last=0, busy=0, overflow=0, load_rdy=1.
- Reset mid-transfer aborts the block. No partial resume; the pending block is discarded.
- Handshake: a byte transfers on a cycle with out_valid && out_ready. While out_valid && !out_ready, out_data, out_first and out_last hold stable. out_valid never drops without a transfer, except on reset.
- Load acceptance: load && load_rdy accepts the block.
  - Active slot empty: capture directly into active; out_valid=1 on the next cycle (1-cycle latency).
  - Active slot full: capture into pending; load_rdy=0 from the next cycle.
- Dropped load: load && !load_rdy drops the block and sets overflow on the next edge.
  - This applies even if the active block finishes in the same cycle.
  - clr_ovf and a new drop in the same cycle: overflow stays 1 (set wins).
- FSM states:
  - IDLE: out_valid=0. Go to HDR (HEADER_EN=1) or DATA (HEADER_EN=0) when a block enters active.
  - HDR: out_data=HDR_BASE|mode, out_first=1. Transfer -> DATA with count=0.
  - DATA: out_data=byte[count]. Byte order: w0,w1,w2,w3,x0,x1,x2,x3,y0,y1,y2,y3,z0,z1,z2,z3 (count 0..15, 4-bit). out_first=1 at count 0 only when HEADER_EN=0; out_last=1 at count 15.
  - On transfer at count 15 (wrap):
    - Pending full: pending moves to active on the same edge, pending clears (load_rdy=1 next cycle), and the FSM enters HDR/DATA with out_valid staying 1 (no bubble).
    - Pending empty: active clears and the FSM returns to IDLE.
- Loads landing in active or pending are never corrupted by later load inputs.
- busy=1 in any state other than IDLE.

Test Plan:
1. HEADER_EN=1; load w0..z3=8'h00..8'h0F, mode_in=1; out_ready=1 -> 17 bytes on consecutive cycles: A1,00,01,..,0F. out_first on A1, out_last on 0F, then busy=0.
2. Same block with out_ready toggled 1,0,1,0 -> each byte held stable while ready=0. Sequence unchanged, 17 transfers total.
3. Load block A (mode 0, bytes 10..1F), then block B (mode 1, bytes 20..2F) two cycles later; out_ready=1 -> load_rdy=0 after B. Stream is A0,10..1F,A1,20..2F with no idle cycle between 1F and A1.
4. With active and pending both full, pulse load with block C -> overflow=1, C never appears. clr_ovf -> overflow=0 next cycle.
5. HEADER_EN=0; load bytes F0..FF -> 16 bytes, out_first on F0, out_last on FF.
6. Assert rst after byte 5 of a block -> all outputs at reset values immediately. A new load afterwards streams from its header.
